tx_bram_loader: RTL and testbench

- Writer side of the 64-bit packet BRAM that the dot11_tx datapath reads through bram_addr/bram_din.
- Accepts a packet as a byte stream and packs 8 bytes per BRAM word, little-endian, starting at word 0.
- After the last word is written it issues a single-cycle phy_tx_start, then holds off the next packet until phy_tx_done.
- Sits between the host/DMA byte stream and the BRAM port A; dot11_tx owns port B.

---
 rtl/tx_bram_loader.sv | 182 ++++++++++++++++++
 tb/tb_tx_bram_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_bram_loader.sv
// Byte-stream to 64-bit BRAM packer for the dot11_tx packet buffer.
// Packs bytes little-endian into port-A words, then kicks dot11_tx and waits for its done pulse.
module tx_bram_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    phy_tx_arestn,
  input  logic [7:0]              s_byte_data,
  input  logic                    s_byte_valid,
  input  logic                    s_byte_last,
  output logic                    s_byte_ready,
  output logic                    bram_we,
  output logic [ADDR_WIDTH-1:0]   bram_waddr,
  output logic [63:0]             bram_dout,
  output logic                    phy_tx_start,
  input  logic                    phy_tx_done,
  output logic [ADDR_WIDTH+2:0]   pkt_len,
  output logic                    ovf,
  output logic                    busy
);

  localparam logic [1:0] FILL      = 2'd0;
  localparam logic [1:0] DROP      = 2'd1;
  localparam logic [1:0] KICK      = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [63:0]           pack_q, pack_d;
  logic [2:0]            lane_q, lane_d;
  logic [ADDR_WIDTH:0]   waddr_q, waddr_d;
  logic [ADDR_WIDTH+3:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] bram_waddr_q, bram_waddr_d;
  logic [63:0]           dout_q, dout_d;
  logic                  start_q, start_d;
  logic [ADDR_WIDTH+2:0] pkt_len_q, pkt_len_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;

  logic                  accept_s;
  logic [63:0]           pack_next_s;
  logic [ADDR_WIDTH+3:0] cnt_inc_s;
  logic [ADDR_WIDTH:0]   waddr_inc_s;

  assign accept_s    = s_byte_valid & ready_q;
  assign pack_next_s = pack_q | ({56'd0, s_byte_data} << {lane_q, 3'b000});
  assign cnt_inc_s   = cnt_q + {{(ADDR_WIDTH+3){1'b0}}, 1'b1};
  assign waddr_inc_s = waddr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Next-state, packing and output computation
  always_comb begin
    state_d      = state_q;
    pack_d       = pack_q;
    lane_d       = lane_q;
    waddr_d      = waddr_q;
    cnt_d        = cnt_q;
    we_d         = 1'b0;
    bram_waddr_d = bram_waddr_q;
    dout_d       = dout_q;
    start_d      = 1'b0;
    pkt_len_d    = pkt_len_q;
    ovf_d        = ovf_q;
    case (state_q)
      FILL: begin
        if (accept_s && waddr_q[ADDR_WIDTH]) begin
          // Word index has run past the BRAM: discard and flag.
          ovf_d  = 1'b1;
          pack_d = 64'd0;
          lane_d = 3'd0;
          if (s_byte_last) begin
            pkt_len_d = cnt_inc_s[ADDR_WIDTH+2:0];
            cnt_d     = '0;
            waddr_d   = '0;
          end else begin
            cnt_d   = cnt_inc_s;
            state_d = DROP;
          end
        end else if (accept_s) begin
          cnt_d = cnt_inc_s;
          if ((lane_q == 3'd7) || s_byte_last) begin
            we_d         = 1'b1;
            bram_waddr_d = waddr_q[ADDR_WIDTH-1:0];
            dout_d       = pack_next_s;
            pack_d       = 64'd0;
            lane_d       = 3'd0;
            waddr_d      = waddr_inc_s;
          end else begin
            pack_d = pack_next_s;
            lane_d = lane_q + 3'd1;
          end
          if (s_byte_last) begin
            pkt_len_d = cnt_inc_s[ADDR_WIDTH+2:0];
            ovf_d     = 1'b0;
            cnt_d     = '0;
            state_d   = KICK;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      DROP: begin
        if (accept_s && s_byte_last) begin
          pkt_len_d = cnt_inc_s[ADDR_WIDTH+2:0];
          cnt_d     = '0;
          waddr_d   = '0;
          state_d   = FILL;
        end else if (accept_s) begin
          cnt_d = cnt_inc_s;
        end else begin
          state_d = DROP;
        end
      end
      KICK: begin
        start_d = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done arriving alongside our own start pulse belongs to nothing we sent.
        if (phy_tx_done && !start_q) begin
          waddr_d = '0;
          lane_d  = 3'd0;
          pack_d  = 64'd0;
          cnt_d   = '0;
          state_d = FILL;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
    ready_d = (state_d == FILL) || (state_d == DROP);
    busy_d  = (state_d != FILL);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge phy_tx_arestn) begin
    if (!phy_tx_arestn) begin
      state_q      <= FILL;
      pack_q       <= 64'd0;
      lane_q       <= 3'd0;
      waddr_q      <= '0;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      bram_waddr_q <= '0;
      dout_q       <= 64'd0;
      start_q      <= 1'b0;
      pkt_len_q    <= '0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pack_q       <= pack_d;
      lane_q       <= lane_d;
      waddr_q      <= waddr_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      bram_waddr_q <= bram_waddr_d;
      dout_q       <= dout_d;
      start_q      <= start_d;
      pkt_len_q    <= pkt_len_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  assign s_byte_ready = ready_q;
  assign bram_we      = we_q;
  assign bram_waddr   = bram_waddr_q;
  assign bram_dout    = dout_q;
  assign phy_tx_start = start_q;
  assign pkt_len      = pkt_len_q;
  assign ovf          = ovf_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_tx_bram_loader.sv
// Directed bench for tx_bram_loader built with a 4-word BRAM so overflow is reachable.
// pkt_len is ADDR_WIDTH+3 = 5 bits wide here, so byte counts are expected modulo 32.
module tb_tx_bram_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    s_byte_data = 8'd0;
  logic          s_byte_valid = 1'b0;
  logic          s_byte_last = 1'b0;
  logic          s_byte_ready;
  logic          bram_we;
  logic [AW-1:0] bram_waddr;
  logic [63:0]   bram_dout;
  logic          phy_tx_start;
  logic          phy_tx_done = 1'b0;
  logic [AW+2:0] pkt_len;
  logic          ovf;
  logic          busy;

  tx_bram_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .phy_tx_arestn(rst_n),
    .s_byte_data(s_byte_data), .s_byte_valid(s_byte_valid), .s_byte_last(s_byte_last),
    .s_byte_ready(s_byte_ready), .bram_we(bram_we), .bram_waddr(bram_waddr),
    .bram_dout(bram_dout), .phy_tx_start(phy_tx_start), .phy_tx_done(phy_tx_done),
    .pkt_len(pkt_len), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int nwr = 0;
  int nstart = 0;
  int last_we_cyc = 0;
  int start_cyc = 0;
  logic [63:0]   wr_data [8];
  logic [AW-1:0] wr_addr [8];
  logic [7:0]    pkt [64];

  typedef struct {
    int           n;
    int           max_gap;
    logic [127:0] bytes;
    int           exp_nwr;
    logic [255:0] exp_words;
    int           exp_len;
  } vec_t;
  vec_t vecs [4];

  always @(posedge clk) cyc++;

  // Log write and start activity away from the active edge
  always @(negedge clk) begin
    if (bram_we) begin
      if (nwr < 8) begin
        wr_data[nwr] = bram_dout;
        wr_addr[nwr] = bram_waddr;
      end
      nwr++;
      last_we_cyc = cyc;
    end
    if (phy_tx_start) begin
      nstart++;
      start_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    nwr = 0;
    nstart = 0;
  endtask

  task automatic send_pkt(input int n, input int max_gap, input bit do_last);
    int t;
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      s_byte_valid = 1'b1;
      s_byte_data  = pkt[i];
      s_byte_last  = do_last && (i == n - 1);
      t = 0;
      while (!s_byte_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
      s_byte_valid = 1'b0;
      s_byte_last  = 1'b0;
    end
  endtask

  task automatic check_pkt(input string nm, input int exp_nwr, input logic [255:0] words,
                           input int exp_start, input int exp_len, input logic exp_ovf);
    repeat (4) @(negedge clk);
    chk({nm, "_nwr"}, 64'(nwr), 64'(exp_nwr));
    for (int i = 0; i < exp_nwr && i < 4; i++) begin
      chk({nm, "_addr"}, 64'(wr_addr[i]), 64'(i));
      chk({nm, "_word"}, wr_data[i], words[64*i +: 64]);
    end
    chk({nm, "_nstart"}, 64'(nstart), 64'(exp_start));
    if (exp_start > 0) chk({nm, "_start_lat"}, 64'(start_cyc), 64'(last_we_cyc + 1));
    chk({nm, "_pkt_len"}, 64'(pkt_len), 64'(exp_len % 32));
    chk({nm, "_ovf"}, 64'(ovf), 64'(exp_ovf));
  endtask

  task automatic finish_tx(input string nm);
    chk({nm, "_ready_wait"}, 64'(s_byte_ready), 64'd0);
    chk({nm, "_busy_wait"}, 64'(busy), 64'd1);
    phy_tx_done = 1'b1;
    @(negedge clk);
    phy_tx_done = 1'b0;
    chk({nm, "_ready_after_done"}, 64'(s_byte_ready), 64'd1);
    chk({nm, "_busy_after_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0] = '{16, 0, 128'h0F0E0D0C0B0A09080706050403020100, 2,
                {128'd0, 64'h0F0E0D0C0B0A0908, 64'h0706050403020100}, 16};
    vecs[1] = '{3, 0, 128'h0000000000CCBBAA, 1, {192'd0, 64'h0000000000CCBBAA}, 3};
    vecs[2] = '{9, 0, 128'h191817161514131211, 2,
                {128'd0, 64'h0000000000000019, 64'h1817161514131211}, 9};
    vecs[3] = '{9, 3, 128'h191817161514131211, 2,
                {128'd0, 64'h0000000000000019, 64'h1817161514131211}, 9};

    repeat (3) @(negedge clk);
    chk("rst_we", 64'(bram_we), 64'd0);
    chk("rst_outs", 64'({bram_waddr, phy_tx_start, pkt_len, ovf, busy, s_byte_ready}), 64'd0);
    chk("rst_dout", bram_dout, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(s_byte_ready), 64'd1);

    for (int v = 0; v < 4; v++) begin
      clr_mon();
      for (int i = 0; i < vecs[v].n; i++) pkt[i] = vecs[v].bytes[8*i +: 8];
      send_pkt(vecs[v].n, vecs[v].max_gap, 1'b1);
      chk($sformatf("vec%0d_ready_drop", v), 64'(s_byte_ready), 64'd0);
      check_pkt($sformatf("vec%0d", v), vecs[v].exp_nwr, vecs[v].exp_words, 1, vecs[v].exp_len, 1'b0);
      finish_tx($sformatf("vec%0d", v));
    end

    // Overflow: 33 bytes into a 4-word BRAM
    clr_mon();
    for (int i = 0; i < 33; i++) pkt[i] = 8'(i);
    send_pkt(33, 0, 1'b1);
    check_pkt("ovf33", 4, {64'h1F1E1D1C1B1A1918, 64'h1716151413121110,
                           64'h0F0E0D0C0B0A0908, 64'h0706050403020100}, 0, 33, 1'b1);
    chk("ovf33_ready", 64'(s_byte_ready), 64'd1);
    chk("ovf33_busy", 64'(busy), 64'd0);
    clr_mon();
    for (int i = 0; i < 8; i++) pkt[i] = 8'(8'h50 + i);
    send_pkt(8, 0, 1'b1);
    check_pkt("after_ovf", 1, {192'd0, 64'h5756555453525150}, 1, 8, 1'b0);
    finish_tx("after_ovf");

    // Overflow that continues through DROP for several more bytes
    clr_mon();
    for (int i = 0; i < 40; i++) pkt[i] = 8'(8'hA0 + i);
    send_pkt(40, 0, 1'b1);
    chk("drop40_nwr", 64'(nwr), 64'd4);
    chk("drop40_nstart", 64'(nstart), 64'd0);
    chk("drop40_len", 64'(pkt_len), 64'(40 % 32));
    chk("drop40_ovf", 64'(ovf), 64'd1);
    chk("drop40_ready", 64'(s_byte_ready), 64'd1);

    // phy_tx_done in FILL, then across the KICK and start cycles: all ignored
    phy_tx_done = 1'b1;
    @(negedge clk);
    phy_tx_done = 1'b0;
    chk("done_in_fill_ready", 64'(s_byte_ready), 64'd1);
    chk("done_in_fill_busy", 64'(busy), 64'd0);
    clr_mon();
    pkt[0] = 8'h11; pkt[1] = 8'h22;
    send_pkt(2, 0, 1'b1);
    phy_tx_done = 1'b1;
    @(negedge clk);
    chk("kick_start_seen", 64'(phy_tx_start), 64'd1);
    @(negedge clk);
    phy_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("kick_done_ignored_ready", 64'(s_byte_ready), 64'd0);
    chk("kick_nstart", 64'(nstart), 64'd1);
    chk("kick_word", wr_data[0], 64'h0000000000002211);
    finish_tx("kick");

    // Asynchronous reset in the middle of a packet
    clr_mon();
    for (int i = 0; i < 5; i++) pkt[i] = 8'(8'hE0 + i);
    send_pkt(5, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", 64'({bram_we, bram_waddr, phy_tx_start, pkt_len, ovf, busy, s_byte_ready}), 64'd0);
    chk("async_rst_dout", bram_dout, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_mon();
    for (int i = 0; i < 8; i++) pkt[i] = 8'(8'h80 + i);
    send_pkt(8, 0, 1'b1);
    check_pkt("post_rst", 1, {192'd0, 64'h8786858483828180}, 1, 8, 1'b0);
    finish_tx("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
